palette_loader: RTL

- Sequences runtime loading of the 64-entry custom palette RAM in the video output stage.
- Accepts a byte-serial palette download (R,G,B byte triplets), packs each triplet into a 24-bit entry, and drives the palette RAM write strobe, index and data.
- Write strobes are issued only during vertical blanking by default, so the RAM's read path (active pixel lookup) is never disturbed mid-frame.
- Reports progress and completion to the system/menu layer, which switches the palette select to custom.

---
 rtl/palette_loader.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/palette_loader.sv
// Palette RAM download sequencer: packs byte-serial R,G,B triplets into 24-bit
// entries and writes them to the palette RAM, by default only during vertical blanking.
module palette_loader #(
  parameter int unsigned NUM_ENTRIES = 64,
  parameter bit          BLANK_ONLY  = 1'b1,
  localparam int unsigned IDX_W      = $clog2(NUM_ENTRIES),
  localparam int unsigned CNT_W      = $clog2(NUM_ENTRIES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dl_start,
  input  logic             dl_end,
  input  logic             dl_valid,
  input  logic [7:0]       dl_data,
  output logic             dl_ready,
  input  logic             vblank,
  output logic             load_color,
  output logic [IDX_W-1:0] load_color_index,
  output logic [23:0]      load_color_data,
  output logic             busy,
  output logic             done,
  output logic             short_err,
  output logic [CNT_W-1:0] entry_count
);

  localparam int unsigned PHASE_W = 2;
  localparam int unsigned BYTE_W  = 8;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    WAIT_BLANK,
    WRITE,
    DRAIN,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [BYTE_W-1:0]  red_q, red_d;
  logic [BYTE_W-1:0]  green_q, green_d;
  logic [BYTE_W-1:0]  blue_q, blue_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   count_inc;
  logic               end_q, end_d;
  logic               load_q, load_d;
  logic [IDX_W-1:0]   index_q, index_d;
  logic [23:0]        data_q, data_d;
  logic               done_q, done_d;
  logic               short_q, short_d;
  logic               busy_q, busy_d;
  logic               xfer;
  logic               triplet_done;

  assign dl_ready     = (state_q == COLLECT) || (state_q == DRAIN);
  assign xfer         = dl_valid && dl_ready;
  assign triplet_done = xfer && (state_q == COLLECT) && (phase_q == PHASE_W'(2));
  assign count_inc    = count_q + CNT_W'(1);

  // A new download cancels a strobe that would otherwise land in the same cycle.
  assign load_color       = load_q && !dl_start;
  assign load_color_index = index_q;
  assign load_color_data  = data_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign short_err        = short_q;
  assign entry_count      = count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      phase_q <= '0;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
      count_q <= '0;
      end_q   <= 1'b0;
      load_q  <= 1'b0;
      index_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      short_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
      count_q <= count_d;
      end_q   <= end_d;
      load_q  <= load_d;
      index_q <= index_d;
      data_q  <= data_d;
      done_q  <= done_d;
      short_q <= short_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    red_d   = red_q;
    green_d = green_q;
    blue_d  = blue_q;
    count_d = count_q;
    end_d   = end_q;
    index_d = index_q;
    data_d  = data_q;
    done_d  = done_q;
    short_d = short_q;

    if (dl_start) begin
      state_d = COLLECT;
      phase_d = '0;
      count_d = '0;
      end_d   = 1'b0;
      done_d  = 1'b0;
      short_d = 1'b0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (xfer) begin
            case (phase_q)
              PHASE_W'(0): begin
                red_d   = dl_data;
                phase_d = PHASE_W'(1);
              end
              PHASE_W'(1): begin
                green_d = dl_data;
                phase_d = PHASE_W'(2);
              end
              default: begin
                blue_d  = dl_data;
                phase_d = '0;
                state_d = WAIT_BLANK;
                end_d   = dl_end;
              end
            endcase
          end
          // End without a complete triplet: any partial bytes are dropped.
          if (dl_end && !triplet_done) begin
            state_d = DONE;
            phase_d = '0;
            short_d = 1'b1;
          end
        end
        WAIT_BLANK: begin
          if (dl_end) begin
            end_d = 1'b1;
          end
          if (!BLANK_ONLY || vblank) begin
            state_d = WRITE;
          end
        end
        WRITE: begin
          count_d = count_inc;
          if (end_q || dl_end) begin
            state_d = DONE;
            end_d   = 1'b0;
            if (count_inc == CNT_W'(NUM_ENTRIES)) begin
              done_d = 1'b1;
            end else begin
              short_d = 1'b1;
            end
          end else if (count_inc == CNT_W'(NUM_ENTRIES)) begin
            state_d = DRAIN;
          end else begin
            state_d = COLLECT;
          end
        end
        DRAIN: begin
          if (dl_end) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end

    // Address and data are captured on entry to WRITE and held afterwards.
    load_d = (state_d == WRITE);
    if (load_d) begin
      index_d = count_q[IDX_W-1:0];
      data_d  = {red_d, green_d, blue_d};
    end

    busy_d = (state_d == COLLECT) || (state_d == WAIT_BLANK) ||
             (state_d == WRITE)   || (state_d == DRAIN);
  end

endmodule
